// File: rtl/pe_array_pkg.sv
// pe_array_pkg: shared sizing, FSM state type and helpers for the PE array controller.
package pe_array_pkg;
  localparam int BIT_WIDTH = 8;
  localparam int SYSTOLIC_DEPTH = 4;
  localparam int SYSTOLIC_COLUMN = 16;
  localparam int VEC_CNT_W = 10;
  localparam int ACC_WIDTH = 2 * BIT_WIDTH + SYSTOLIC_DEPTH - 1;
  localparam int SKEW_LEN = SYSTOLIC_DEPTH + SYSTOLIC_COLUMN;
  typedef enum logic [1:0] {IDLE, LOAD_WT, STREAM, DRAIN} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/pe_array_ctrl_if.sv
// pe_array_ctrl_if: tile-buffer handshakes, array drive pins and result strobes of the PE array controller.
interface pe_array_ctrl_if #(
  parameter int BIT_WIDTH = pe_array_pkg::BIT_WIDTH,
  parameter int SYSTOLIC_DEPTH = pe_array_pkg::SYSTOLIC_DEPTH,
  parameter int SYSTOLIC_COLUMN = pe_array_pkg::SYSTOLIC_COLUMN,
  parameter int VEC_CNT_W = pe_array_pkg::VEC_CNT_W
);
  logic start;
  logic [VEC_CNT_W-1:0] n_vec;
  logic wt_valid;
  logic wt_ready;
  logic [BIT_WIDTH*SYSTOLIC_COLUMN-1:0] wt_data;
  logic act_valid;
  logic act_ready;
  logic [BIT_WIDTH*SYSTOLIC_DEPTH-1:0] act_data;
  logic pe_is_wt;
  logic [BIT_WIDTH*SYSTOLIC_COLUMN-1:0] pe_wt_in;
  logic [BIT_WIDTH*SYSTOLIC_DEPTH-1:0] pe_data_in;
  logic [SYSTOLIC_COLUMN-1:0] res_valid;
  logic res_last;
  logic busy;
  logic done;
  modport master (
    output start, n_vec, wt_valid, wt_data, act_valid, act_data,
    input wt_ready, act_ready, pe_is_wt, pe_wt_in, pe_data_in, res_valid, res_last, busy, done
  );
  modport slave (
    input start, n_vec, wt_valid, wt_data, act_valid, act_data,
    output wt_ready, act_ready, pe_is_wt, pe_wt_in, pe_data_in, res_valid, res_last, busy, done
  );
endinterface

// File: rtl/pe_array_ctrl_skew.sv
// pe_skew_line: N-stage register delay exposing every stage; tap[k] is the input delayed by k cycles.
module pe_skew_line #(
  parameter int W = 8,
  parameter int N = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        d,
  output logic [N:0][W-1:0]   tap
);
  if (N == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk = clk ^ rst;
    assign tap = d;
  end else begin : g_reg
    logic [N-1:0][W-1:0] q;
    always_ff @(posedge clk or posedge rst)
      if (rst) q <= '0;
      else begin
        q[0] <= d;
        for (int i = 1; i < N; i++) q[i] <= q[i-1];
      end
    assign tap = {q, d};
  end
endmodule

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: weight-load / skewed-activation sequencer for the systolic MAC array.
// Define PE_ARRAY_CTRL_PERF_EN to add the busy/stall cycle counters.
module pe_array_ctrl
  import pe_array_pkg::*;
#(
  parameter int BIT_WIDTH = pe_array_pkg::BIT_WIDTH,
  parameter int SYSTOLIC_DEPTH = pe_array_pkg::SYSTOLIC_DEPTH,
  parameter int SYSTOLIC_COLUMN = pe_array_pkg::SYSTOLIC_COLUMN,
  parameter int VEC_CNT_W = pe_array_pkg::VEC_CNT_W
) (
  input logic clk,
  input logic rst,
  pe_array_ctrl_if.slave bus
`ifdef PE_ARRAY_CTRL_PERF_EN
  ,
  output logic [31:0] perf_busy_cyc,
  output logic [31:0] perf_stall_cyc
`endif
);
  localparam int SL = SYSTOLIC_DEPTH + SYSTOLIC_COLUMN;
  localparam int WCW = clog2(SYSTOLIC_DEPTH + 1);
  state_t state;
  logic [VEC_CNT_W-1:0] n_lat, vcnt;
  logic [WCW-1:0] wcnt;
  logic [BIT_WIDTH*SYSTOLIC_DEPTH-1:0] act_q;
  logic [SL:0] vline;
  logic wt_hs, act_hs, drain_end;
  assign bus.wt_ready = state == LOAD_WT;
  assign bus.act_ready = state == STREAM;
  assign bus.busy = state != IDLE;
  assign wt_hs = bus.wt_valid & bus.wt_ready;
  assign act_hs = bus.act_valid & bus.act_ready;
  // Only the final column's tap may still be set once the tile is otherwise flushed.
  assign drain_end = (state == DRAIN) && (vline[SL-1:0] == '0);
  assign bus.res_last = drain_end;
  assign bus.res_valid = vline[SL:SYSTOLIC_DEPTH+1];
  pe_skew_line #(.W(1), .N(SL)) u_vld (.clk(clk), .rst(rst), .d(act_hs), .tap(vline));
  for (genvar r = 0; r < SYSTOLIC_DEPTH; r++) begin : g_lane
    logic [r:0][BIT_WIDTH-1:0] t;
    pe_skew_line #(.W(BIT_WIDTH), .N(r)) u_skew (
      .clk(clk), .rst(rst), .d(act_q[r*BIT_WIDTH+:BIT_WIDTH]), .tap(t)
    );
    assign bus.pe_data_in[r*BIT_WIDTH+:BIT_WIDTH] = t[r];
    if (r > 0) begin : g_lo
      logic unused_taps;
      assign unused_taps = ^t[r-1:0];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      n_lat <= '0;
      vcnt <= '0;
      wcnt <= '0;
      act_q <= '0;
      bus.pe_is_wt <= 1'b0;
      bus.pe_wt_in <= '0;
      bus.done <= 1'b0;
    end else begin
      bus.pe_is_wt <= wt_hs;
      bus.done <= drain_end;
      act_q <= act_hs ? bus.act_data : '0;
      if (wt_hs) bus.pe_wt_in <= bus.wt_data;
      case (state)
        IDLE: if (bus.start) begin
          state <= LOAD_WT;
          n_lat <= bus.n_vec;
          wcnt <= '0;
          vcnt <= '0;
        end
        LOAD_WT: if (wt_hs) begin
          wcnt <= wcnt + WCW'(1);
          if (wcnt == WCW'(SYSTOLIC_DEPTH - 1)) state <= (n_lat == '0) ? DRAIN : STREAM;
        end
        STREAM: if (act_hs) begin
          vcnt <= vcnt + VEC_CNT_W'(1);
          if (vcnt == n_lat - VEC_CNT_W'(1)) state <= DRAIN;
        end
        default: if (drain_end) state <= IDLE;
      endcase
    end
`ifdef PE_ARRAY_CTRL_PERF_EN
  logic stall;
  assign stall = (bus.wt_ready & ~bus.wt_valid) | (bus.act_ready & ~bus.act_valid);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_busy_cyc <= '0;
      perf_stall_cyc <= '0;
    end else if (state == IDLE && bus.start) begin
      perf_busy_cyc <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (bus.busy && ~&perf_busy_cyc) perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if (stall && ~&perf_stall_cyc) perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl: randomized tiles checked against a cycle-indexed reference of the controller's timing rules.
module tb_pe_array_ctrl;
  import pe_array_pkg::*;
  localparam int BW = BIT_WIDTH;
  localparam int D = SYSTOLIC_DEPTH;
  localparam int C = SYSTOLIC_COLUMN;
  localparam int NC = 8192;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pe_array_ctrl_if bus ();
`ifdef PE_ARRAY_CTRL_PERF_EN
  logic [31:0] perf_busy_cyc, perf_stall_cyc;
`endif
  pe_array_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef PE_ARRAY_CTRL_PERF_EN
    , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc)
`endif
  );
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit hs_a [NC];
  bit hs_w [NC];
  logic [BW*D-1:0] vec [NC];
  logic [BW*C-1:0] wt_exp = '0;
  int phase = 0;
  int wcnt = 0;
  int acnt = 0;
  int n_lat = 0;
  int last_t = -10;
  int pbusy = 0;
  int pstall = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic eval();
    logic [BW*D-1:0] ed = '0;
    logic [C-1:0] ev = '0;
    for (int r = 0; r < D; r++)
      if (cyc - 1 - r >= 0 && hs_a[cyc-1-r]) ed[r*BW+:BW] = vec[cyc-1-r][r*BW+:BW];
    for (int c = 0; c < C; c++)
      if (cyc - D - 1 - c >= 0) ev[c] = hs_a[cyc-D-1-c];
    check("wt_ready", 128'(bus.wt_ready), 128'(phase == 1));
    check("act_ready", 128'(bus.act_ready), 128'(phase == 2));
    check("busy", 128'(bus.busy), 128'(phase != 0));
    check("pe_is_wt", 128'(bus.pe_is_wt), 128'(cyc > 0 && hs_w[cyc-1]));
    check("pe_wt_in", 128'(bus.pe_wt_in), 128'(wt_exp));
    check("pe_data_in", 128'(bus.pe_data_in), 128'(ed));
    check("res_valid", 128'(bus.res_valid), 128'(ev));
    check("res_last", 128'(bus.res_last), 128'(cyc == last_t));
    check("done", 128'(bus.done), 128'(cyc == last_t + 1));
`ifdef PE_ARRAY_CTRL_PERF_EN
    if (cyc == last_t + 1) begin
      check("perf_busy", 128'(perf_busy_cyc), 128'(pbusy));
      check("perf_stall", 128'(perf_stall_cyc), 128'(pstall));
    end
`endif
  endtask

  task automatic update();
    case (phase)
      0: if (bus.start) begin
        phase = 1; wcnt = 0; acnt = 0; n_lat = int'(bus.n_vec); pbusy = 0; pstall = 0;
      end
      1: begin
        pbusy++;
        if (!bus.wt_valid) pstall++;
        else begin
          hs_w[cyc] = 1'b1;
          wt_exp = bus.wt_data;
          wcnt++;
          if (wcnt == D) begin
            phase = (n_lat == 0) ? 3 : 2;
            if (n_lat == 0) last_t = cyc + 1;
          end
        end
      end
      2: begin
        pbusy++;
        if (!bus.act_valid) pstall++;
        else begin
          hs_a[cyc] = 1'b1;
          vec[cyc] = bus.act_data;
          acnt++;
          if (acnt == n_lat) begin
            phase = 3;
            last_t = cyc + D + C;
          end
        end
      end
      default: begin
        pbusy++;
        if (cyc == last_t) phase = 0;
      end
    endcase
  endtask

  task automatic reset_check();
    check("rst_wt_in", 128'(bus.pe_wt_in), 128'(0));
    check("rst_outs", 128'({bus.wt_ready, bus.act_ready, bus.pe_is_wt, bus.pe_data_in,
                            bus.res_valid, bus.res_last, bus.busy, bus.done}), 128'(0));
`ifdef PE_ARRAY_CTRL_PERF_EN
    check("rst_perf", 128'({perf_busy_cyc, perf_stall_cyc}), 128'(0));
`endif
    phase = 0;
    last_t = -10;
    wt_exp = '0;
    foreach (hs_a[i]) begin
      hs_a[i] = 1'b0;
      hs_w[i] = 1'b0;
    end
  endtask

  task automatic tick(input bit st, input bit wv, input bit av, input bit rs, input int nv);
    @(posedge clk);
    cyc++;
    #1;
    if (cyc >= NC) begin
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, NC);
      $fatal(1);
    end
    rst = rs;
    bus.start = st;
    bus.n_vec = VEC_CNT_W'(nv);
    bus.wt_valid = wv;
    bus.act_valid = av;
    bus.wt_data = {$urandom, $urandom, $urandom, $urandom};
    bus.act_data = $urandom;
    @(negedge clk);
    if (rs) reset_check();
    else begin
      eval();
      update();
    end
  endtask

  task automatic run_tile(input int n, input int pw, input int pa, input int rst_vec);
    tick(1'b1, 1'b0, 1'b1, 1'b0, n);
    for (int k = 0; k < 3000; k++) begin
      if (rst_vec >= 0 && phase == 2 && acnt == rst_vec) begin
        tick(1'b0, 1'b1, 1'b1, 1'b1, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 0);
        return;
      end
      tick(phase != 0 && $urandom_range(0, 5) == 0, $urandom_range(0, 99) < pw,
           $urandom_range(0, 99) < pa, 1'b0, int'($urandom_range(0, 1023)));
      if (phase == 0 && cyc == last_t + 1) return;
    end
    check("tile_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.n_vec = '0;
    bus.wt_valid = 1'b0;
    bus.act_valid = 1'b0;
    bus.wt_data = '0;
    bus.act_data = '0;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_tile(1, 100, 100, -1);
    run_tile(5, 100, 50, -1);
    run_tile(0, 100, 100, -1);
    run_tile(8, 100, 100, 3);
    run_tile(4, 60, 60, -1);
    run_tile(3, 50, 40, -1);
    for (int i = 0; i < 10; i++)
      run_tile(int'($urandom_range(0, 12)), int'($urandom_range(30, 100)),
               int'($urandom_range(30, 100)), -1);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_array_ctrl.md
Name: pe_array_ctrl

Overview:
- Sequencer for the weight-stationary systolic MAC array: loads one weight tile, streams activation vectors with per-row skew, and flags when each column's accumulated result is valid on the array's acc output.
- Sits between the MHA tile buffers (valid/ready sources) and the array's clk/is_wt/data_in/wt_in pins.
- Does not touch acc data; it emits only per-column valid strobes.

Parameters:
- BIT_WIDTH, 8, operand width.
- SYSTOLIC_DEPTH, 4, array rows (activation lanes).
- SYSTOLIC_COLUMN, 16, array columns (weight lanes).
- VEC_CNT_W, 10, width of the vector-count config field.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle launch pulse; sampled only in IDLE.
- n_vec  in  VEC_CNT_W  number of activation vectors to stream; latched on start.
- wt_valid  in  1  weight row word valid.
- wt_ready  out  1  controller accepts weight word.
- wt_data  in  BIT_WIDTH*SYSTOLIC_COLUMN  one weight row.
- act_valid  in  1  activation vector valid.
- act_ready  out  1  controller accepts activation vector.
- act_data  in  BIT_WIDTH*SYSTOLIC_DEPTH  one activation vector; lane r feeds row r.
- pe_is_wt  out  1  drives array is_wt.
- pe_wt_in  out  BIT_WIDTH*SYSTOLIC_COLUMN  drives array wt_in.
- pe_data_in  out  BIT_WIDTH*SYSTOLIC_DEPTH  drives array data_in (skewed).
- res_valid  out  SYSTOLIC_COLUMN  bit c high means array acc column c holds a finished result this cycle.
- res_last  out  1  high with the final column-(SYSTOLIC_COLUMN-1) strobe of the tile.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse, one cycle after the cycle that carries res_last.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. While reset is asserted, every register and output is 0 and the state is IDLE. Reset mid-tile abandons the tile, flushes the skew and valid pipelines, and the array is not reloaded.
- FSM states: IDLE, LOAD_WT, STREAM, DRAIN.
- IDLE to LOAD_WT: on start. Latch n_vec and clear the weight counter. start outside IDLE is ignored.
- LOAD_WT:
  - wt_ready=1.
  - Each handshake (wt_valid & wt_ready) registers wt_data onto pe_wt_in with pe_is_wt=1 in the next cycle.
  - pe_is_wt=0 in every other cycle, so the array holds its weights during stalls.
  - The first accepted word ends in row SYSTOLIC_DEPTH-1; the last word ends in row 0.
  - After SYSTOLIC_DEPTH handshakes the FSM goes to STREAM. If the latched n_vec=0, it goes to DRAIN instead.
- STREAM:
  - act_ready=1 while accepted < n_vec.
  - A handshake in cycle t drives lane r of that vector onto pe_data_in lane r in cycle t+1+r, using r-stage delay lines per lane.
  - A cycle without a handshake inserts a bubble: zero data and a valid tag of 0.
  - After the n_vec-th handshake the FSM goes to DRAIN, and act_ready is 0 from the next cycle.
- Result timing: a vector accepted at cycle t makes res_valid[c]=1 in cycle t+SYSTOLIC_DEPTH+1+c. This is produced by a valid-tag delay line of length SYSTOLIC_DEPTH+SYSTOLIC_COLUMN, tapped per column. Bubbles never raise res_valid.
- DRAIN:
  - The FSM waits until the valid delay line is all zero.
  - res_last is asserted with res_valid[SYSTOLIC_COLUMN-1] for the n_vec-th vector. For n_vec=0, res_last is asserted alone on the DRAIN entry cycle.
  - The FSM then returns to IDLE and pulses done in that transition cycle +1.
- Default output values: pe_data_in lanes are 0 whenever their tag is 0. pe_wt_in holds its last value when pe_is_wt=0.
- Counters: weight counter width clog2(SYSTOLIC_DEPTH+1). Vector counter width VEC_CNT_W, with no wrap because the maximum is n_vec.

Optional Feature:
- Macro: PE_ARRAY_CTRL_PERF_EN.
- When defined:
  - Adds outputs perf_busy_cyc[31:0] and perf_stall_cyc[31:0]. perf_busy_cyc counts cycles with busy=1. perf_stall_cyc counts LOAD_WT/STREAM cycles where ready=1 and valid=0.
  - Both counters saturate at all-ones, clear on start, and reset to 0.
- When undefined: these ports and the counters are absent, and all other behaviour is identical.

Decomposition:
- Shared package pe_array_pkg holds:
  - the state enum;
  - localparams ACC_WIDTH = 2*BIT_WIDTH+SYSTOLIC_DEPTH-1 and SKEW_LEN = SYSTOLIC_DEPTH+SYSTOLIC_COLUMN;
  - a clog2 helper.
- One sub-module, pe_skew_line: a parameterised N-stage register delay with async reset. It is instantiated per activation lane (N=r) and once for the valid tag.

Test Plan:
- Reset mid-STREAM at vector 3 of 8 → all outputs 0 next edge, FSM in IDLE; a new start then loads weights normally.
- Weight load, wt_valid high for 4 cycles with words W0..W3 → pe_is_wt high for exactly 4 cycles carrying W0..W3 in order, then act_ready rises.
- n_vec=1, vector {4,3,2,1} accepted at t=10 → pe_data_in lane0=1 at t=11, lane3=4 at t=14. res_valid[0] at t=15, res_valid[15] plus res_last at t=30, done at t=31.
- n_vec=5 with act_valid low every other cycle → exactly 5 strobes per column, no strobe for bubbles, bubble lanes 0.
- n_vec=0 → after 4 weight words, no act_ready, res_last alone, then done; start pulsed while busy has no effect.
- PE_ARRAY_CTRL_PERF_EN defined, 2 weight stall cycles and 3 activation stall cycles → perf_stall_cyc=5; perf_busy_cyc equals the cycle count from start to done.
